// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for the 1-bit erosion/dilation chain: shadows host mode
// commands, applies them at frame start, tracks pixel coordinates and checks geometry.
module morph_frame_ctrl #(
    parameter logic [10:0] IMG_HDISP = 11'd1024,
    parameter logic [10:0] IMG_VDISP = 11'd768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_mode,
    input  logic        cfg_border,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    output logic [1:0]  stage1_sel,
    output logic [1:0]  stage2_sel,
    output logic        border_flag,
    output logic        border_val,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [1:0]  active_mode,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        size_err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;

    localparam logic [10:0] H_LAST  = IMG_HDISP - 11'd1;
    localparam logic [10:0] V_LAST  = IMG_VDISP - 11'd1;
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    state_t      state;
    logic        vsync_d;
    logic        href_d;
    logic        pending;
    logic [1:0]  shadow_mode;
    logic        shadow_border;
    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic        line_err;
    logic        vs_rise;
    logic        vs_fall;
    logic        href_fall;
    logic        pix_strobe;
    logic        frame_bad;

    function automatic logic [3:0] stage_decode(input logic [1:0] mode);
        logic [3:0] sel;
        case (mode)
            2'b01:   sel = {2'd1, 2'd0};
            2'b10:   sel = {2'd2, 2'd0};
            2'b11:   sel = {2'd1, 2'd2};
            default: sel = {2'd0, 2'd0};
        endcase
        return sel;
    endfunction

    assign vs_rise    = per_frame_vsync & ~vsync_d;
    assign vs_fall    = ~per_frame_vsync & vsync_d;
    assign href_fall  = ~per_frame_href & href_d;
    assign pix_strobe = per_frame_clken & per_frame_href;
    assign frame_bad  = line_err | (y_cnt != IMG_VDISP);

    // vsync_d resets high so a vsync already asserted at reset release is not taken as a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b1;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
        end
    end

    // Apply and accept are mutually exclusive: apply needs pending, accept needs !pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            shadow_mode   <= 2'b00;
            shadow_border <= 1'b0;
            active_mode   <= 2'b00;
            border_val    <= 1'b0;
            stage1_sel    <= 2'd0;
            stage2_sel    <= 2'd0;
        end else if (vs_rise && pending) begin
            active_mode              <= shadow_mode;
            border_val               <= shadow_border;
            {stage1_sel, stage2_sel} <= stage_decode(shadow_mode);
            pending                  <= 1'b0;
        end else if (cfg_valid && !pending) begin
            shadow_mode   <= cfg_mode;
            shadow_border <= cfg_border;
            pending       <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_cnt    <= 11'd0;
            y_cnt    <= 11'd0;
            line_err <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        state    <= ACTIVE;
                        x_cnt    <= 11'd0;
                        y_cnt    <= 11'd0;
                        line_err <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (pix_strobe) begin
                        if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 11'd1;
                    end else if (href_fall) begin
                        if (x_cnt != IMG_HDISP) line_err <= 1'b1;
                        x_cnt <= 11'd0;
                        if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 11'd1;
                    end
                    if (vs_fall) state <= CHECK;
                end
                CHECK: begin
                    if (frame_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    if (vs_rise) begin
                        state    <= ACTIVE;
                        x_cnt    <= 11'd0;
                        y_cnt    <= 11'd0;
                        line_err <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cfg_ready   = ~pending;
    assign frame_busy  = (state == ACTIVE);
    assign frame_done  = (state == CHECK);
    assign size_err    = frame_done & frame_bad;
    assign pix_x       = x_cnt;
    assign pix_y       = y_cnt;
    assign border_flag = per_frame_href & (state == ACTIVE) &
                         ((x_cnt == 11'd0) | (x_cnt == H_LAST) |
                          (y_cnt == 11'd0) | (y_cnt == V_LAST));

endmodule
